// File: rtl/rotation_aligner.sv
// Searches rotation amounts 0..WIDTH-1, one per clock, for the one that turns data_in into pattern.
// Define ROT_ALIGN_COUNT_EN to scan every amount and report how many of them match on match_count.
module rotation_aligner #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] pattern,
  input  logic             lr,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [AMT_W-1:0] amount,
`ifdef ROT_ALIGN_COUNT_EN
  output logic [AMT_W:0]   match_count,
`endif
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [AMT_W-1:0] LAST_CAND = AMT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] data_q, pat_q, rot;
  logic             lr_q;
  logic [AMT_W-1:0] cand;
  logic             hit, last, finish;

`ifdef ROT_ALIGN_COUNT_EN
  logic             best_found;
  logic [AMT_W-1:0] best_amt;
  logic [WIDTH-1:0] best_rot;
  logic [AMT_W:0]   cnt;
`endif

  // Rotation via a doubled word: the upper half of a left shift, or the lower half of a right shift.
  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] d,
                                              input logic [AMT_W-1:0] k,
                                              input logic left);
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d};
    if (left) begin
      dbl = dbl << k;
      rotate = dbl[2*WIDTH-1:WIDTH];
    end else begin
      dbl = dbl >> k;
      rotate = dbl[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    rot  = rotate(data_q, cand, lr_q);
    hit  = (rot == pat_q);
    last = (cand == LAST_CAND);
`ifdef ROT_ALIGN_COUNT_EN
    finish = (state == SEARCH) && last;
`else
    finish = (state == SEARCH) && (hit || last);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SEARCH;
      SEARCH:  if (finish) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Results are committed on the last search cycle so done and the outputs appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      pat_q    <= '0;
      lr_q     <= 1'b0;
      cand     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      amount   <= '0;
      data_out <= '0;
`ifdef ROT_ALIGN_COUNT_EN
      best_found  <= 1'b0;
      best_amt    <= '0;
      best_rot    <= '0;
      cnt         <= '0;
      match_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          data_q <= data_in;
          pat_q  <= pattern;
          lr_q   <= lr;
          cand   <= '0;
          busy   <= 1'b1;
          found  <= 1'b0;
`ifdef ROT_ALIGN_COUNT_EN
          best_found <= 1'b0;
          best_amt   <= '0;
          best_rot   <= '0;
          cnt        <= '0;
`endif
        end
        SEARCH: begin
`ifdef ROT_ALIGN_COUNT_EN
          if (hit) begin
            cnt <= cnt + 1'b1;
            if (!best_found) begin
              best_found <= 1'b1;
              best_amt   <= cand;
              best_rot   <= rot;
            end
          end
          if (finish) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            match_count <= cnt + (AMT_W+1)'(hit);
            if (best_found) begin
              found    <= 1'b1;
              amount   <= best_amt;
              data_out <= best_rot;
            end else if (hit) begin
              found    <= 1'b1;
              amount   <= cand;
              data_out <= rot;
            end else begin
              found    <= 1'b0;
              amount   <= '0;
              data_out <= data_q;
            end
          end else begin
            cand <= cand + 1'b1;
          end
`else
          if (finish) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            found    <= hit;
            amount   <= hit ? cand : '0;
            data_out <= hit ? rot : data_q;
          end else begin
            cand <= cand + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_aligner.sv
// Randomized and directed bench for rotation_aligner against a bit-index rotation model.
// Honours ROT_ALIGN_COUNT_EN the same way the design does.
module tb_rotation_aligner;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst, start, lr;
  logic [WIDTH-1:0] data_in, pattern;
  logic             busy, done, found;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_out;
`ifdef ROT_ALIGN_COUNT_EN
  logic [AMT_W:0]   match_count;
`endif

  int checkCount = 0;
  int passCount  = 0;

  rotation_aligner #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pattern(pattern), .lr(lr),
    .busy(busy), .done(done), .found(found), .amount(amount),
`ifdef ROT_ALIGN_COUNT_EN
    .match_count(match_count),
`endif
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Bit j of a left rotation by k comes from bit j-k of the source (mod WIDTH).
  function automatic logic [WIDTH-1:0] modelRotate(input logic [WIDTH-1:0] d, input int k, input logic left);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (left) r[(i + k) % WIDTH] = d[i];
      else      r[(i - k + WIDTH) % WIDTH] = d[i];
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p, input logic l);
    @(negedge clk);
    data_in = d; pattern = p; lr = l; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_in = WIDTH'($urandom); pattern = WIDTH'($urandom); lr = 1'($urandom);
  endtask

  // Run one search from its start edge and check timing, busy and results.
  task automatic runCase(input string name, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p, input logic l);
    int expFound, expAmt, expCount, expDone;
    logic [WIDTH-1:0] expData;
    expFound = 0; expAmt = 0; expCount = 0; expData = d;
    for (int k = 0; k < WIDTH; k++) begin
      if (modelRotate(d, k, l) == p) begin
        if (expFound == 0) begin
          expFound = 1; expAmt = k; expData = modelRotate(d, k, l);
        end
        expCount++;
      end
    end
`ifdef ROT_ALIGN_COUNT_EN
    expDone = WIDTH + 1;
`else
    expDone = expFound ? expAmt + 2 : WIDTH + 1;
`endif
    applyStimulus(d, p, l);
    for (int n = 1; n <= expDone + 2; n++) begin
      @(negedge clk);
      if (n < expDone) begin
        if (busy !== 1'b1 || done !== 1'b0)
          checkOutput({name, " busy/done mid-search"}, {busy, done}, 2'b10);
      end else if (n == expDone) begin
        checkOutput({name, " done"}, done, 1'b1);
        checkOutput({name, " busy"}, busy, 1'b0);
        checkOutput({name, " found"}, found, expFound);
        checkOutput({name, " amount"}, amount, expAmt);
        checkOutput({name, " data_out"}, data_out, expData);
`ifdef ROT_ALIGN_COUNT_EN
        checkOutput({name, " match_count"}, match_count, expCount);
`endif
      end else if (n == expDone + 1) begin
        checkOutput({name, " done pulse width"}, done, 1'b0);
      end else begin
        checkOutput({name, " hold"}, {found, amount, data_out}, {1'(expFound), AMT_W'(expAmt), expData});
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lr = 1'b0; data_in = '0; pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs", {busy, done, found, amount, data_out}, '0);
    rst = 1'b0;

    runCase("s1", 8'b10010010, 8'b10010100, 1'b1);
    runCase("s2", 8'b10010010, 8'b10010100, 1'b0);
    runCase("s3", 8'b10010010, 8'b10010010, 1'b1);
    runCase("s4", 8'b10010010, 8'hFF, 1'b1);
    runCase("s5", 8'b10101010, 8'b01010101, 1'b1);

    // Start case 4, pulse start mid-search, then reset before it completes.
    begin
      logic sawDone;
      applyStimulus(8'b10010010, 8'hFF, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkOutput("s6 busy after ignored start", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("s6 outputs after abort", {busy, done, found, amount, data_out}, '0);
      sawDone = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (done) sawDone = 1'b1;
      end
      checkOutput("s6 no done after abort", sawDone, 1'b0);
    end
    runCase("s6 restart", 8'b10010010, 8'b10010100, 1'b1);

    // Random cases: half are guaranteed rotations of the source, half are arbitrary pairs.
    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] d, p;
      logic l;
      d = WIDTH'($urandom);
      l = 1'($urandom);
      if (t % 2 == 0) p = modelRotate(d, $urandom_range(WIDTH - 1), 1'($urandom));
      else            p = WIDTH'($urandom);
      runCase($sformatf("rand%0d", t), d, p, l);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
